// File: rtl/mem_port32_if.sv
// Request/response handshake between a load/store client and mem_port32.
// The client uses the master modport; mem_port32 uses the slave modport.
interface mem_port32_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_sz;
    logic        req_sgn;
    logic [16:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_sz, req_sgn, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_sz, req_sgn, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/mem_port32.sv
// Byte-addressed load/store front end for a 32K x 32 SPRAM with four byte lanes.
// Splits word-crossing accesses into two SPRAM cycles and aligns/extends read data.
module mem_port32 (
    input  logic               clk,
    input  logic               rst,
    mem_port32_if.slave        bus,
    output logic               mem_we,
    output logic [3:0]         mem_bmsk,
    output logic [14:0]        mem_a,
    output logic [31:0]        mem_vi,
    input  logic [31:0]        mem_vo
);

    typedef enum logic [2:0] {
        IDLE,
        A1,
        R1,
        A2,
        R2,
        DONE
    } state_t;

    state_t      state_q;
    logic        we_q;
    logic        sgn_q;
    logic [1:0]  sz_q;
    logic [1:0]  off_q;
    logic        split_q;
    logic [14:0] a1_q;
    logic [3:0]  bmsk1_q;
    logic [31:0] word0_q;

    logic [1:0]  req_szn;
    logic [3:0]  req_nmask;
    logic [7:0]  req_span;
    logic [31:0] req_wrot;
    logic [31:0] rd_lo;
    logic [31:0] rd_shift;
    logic [31:0] rd_result;

    // Request decode: req_span covers both words, lanes 7:4 belong to word 1.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        req_szn   = 2'd2;
        req_nmask = 4'b1111;
        case (bus.req_sz)
            2'd0: begin
                req_szn   = 2'd0;
                req_nmask = 4'b0001;
            end
            2'd1: begin
                req_szn   = 2'd1;
                req_nmask = 4'b0011;
            end
            default: begin
                req_szn   = 2'd2;
                req_nmask = 4'b1111;
            end
        endcase
        req_span = {4'b0000, req_nmask} << bus.req_addr[1:0];

        req_wrot = bus.req_wdata;
        case (bus.req_addr[1:0])
            2'd1:    req_wrot = {bus.req_wdata[23:0], bus.req_wdata[31:24]};
            2'd2:    req_wrot = {bus.req_wdata[15:0], bus.req_wdata[31:16]};
            2'd3:    req_wrot = {bus.req_wdata[7:0],  bus.req_wdata[31:8]};
            default: req_wrot = bus.req_wdata;
        endcase
    end

    // Read assembly: {word1, word0} >> 8*offset, then trim to size and extend.
    always_comb begin
        rd_lo    = split_q ? word0_q : mem_vo;
        rd_shift = rd_lo;
        case (off_q)
            2'd1:    rd_shift = {mem_vo[7:0],  rd_lo[31:8]};
            2'd2:    rd_shift = {mem_vo[15:0], rd_lo[31:16]};
            2'd3:    rd_shift = {mem_vo[23:0], rd_lo[31:24]};
            default: rd_shift = rd_lo;
        endcase

        rd_result = rd_shift;
        case (sz_q)
            2'd0:    rd_result = {{24{sgn_q & rd_shift[7]}},  rd_shift[7:0]};
            2'd1:    rd_result = {{16{sgn_q & rd_shift[15]}}, rd_shift[15:0]};
            default: rd_result = rd_shift;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            mem_we        <= 1'b0;
            mem_bmsk      <= '0;
            mem_a         <= '0;
            mem_vi        <= '0;
            we_q          <= 1'b0;
            sgn_q         <= 1'b0;
            sz_q          <= 2'd0;
            off_q         <= 2'd0;
            split_q       <= 1'b0;
            a1_q          <= '0;
            bmsk1_q       <= '0;
            word0_q       <= '0;
        end else begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q          <= bus.req_we;
                        sgn_q         <= bus.req_sgn;
                        sz_q          <= req_szn;
                        off_q         <= bus.req_addr[1:0];
                        split_q       <= |req_span[7:4];
                        a1_q          <= bus.req_addr[16:2] + 15'd1;
                        bmsk1_q       <= req_span[7:4];
                        mem_a         <= bus.req_addr[16:2];
                        mem_we        <= bus.req_we;
                        mem_bmsk      <= bus.req_we ? req_span[3:0] : 4'b0000;
                        mem_vi        <= req_wrot;
                        bus.req_ready <= 1'b0;
                        state_q       <= A1;
                    end
                end
                A1: begin
                    if (we_q) begin
                        if (split_q) begin
                            mem_a    <= a1_q;
                            mem_bmsk <= bmsk1_q;
                            state_q  <= A2;
                        end else begin
                            mem_we        <= 1'b0;
                            mem_bmsk      <= '0;
                            bus.rsp_valid <= 1'b1;
                            state_q       <= DONE;
                        end
                    end else begin
                        // mem_a stays put: the SPRAM output mux follows the live address.
                        state_q <= split_q ? R1 : R2;
                    end
                end
                R1: begin
                    word0_q <= mem_vo;
                    mem_a   <= a1_q;
                    state_q <= A2;
                end
                A2: begin
                    if (we_q) begin
                        mem_we        <= 1'b0;
                        mem_bmsk      <= '0;
                        bus.rsp_valid <= 1'b1;
                        state_q       <= DONE;
                    end else begin
                        state_q <= R2;
                    end
                end
                R2: begin
                    bus.rsp_rdata <= rd_result;
                    bus.rsp_valid <= 1'b1;
                    state_q       <= DONE;
                end
                DONE: begin
                    mem_we        <= 1'b0;
                    bus.req_ready <= 1'b1;
                    state_q       <= IDLE;
                end
                default: begin
                    mem_we        <= 1'b0;
                    mem_bmsk      <= '0;
                    bus.req_ready <= 1'b1;
                    state_q       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port32.sv
// Directed bench for mem_port32 with a two-bank SPRAM model whose output mux
// follows the live mem_a bank bit, so a moved address corrupts read data.
module tb_mem_port32;

    logic        clk;
    logic        rst;
    logic        mem_we;
    logic [3:0]  mem_bmsk;
    logic [14:0] mem_a;
    logic [31:0] mem_vi;
    logic [31:0] mem_vo;

    mem_port32_if bus ();

    mem_port32 dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .mem_we   (mem_we),
        .mem_bmsk (mem_bmsk),
        .mem_a    (mem_a),
        .mem_vi   (mem_vi),
        .mem_vo   (mem_vo)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SPRAM model: registered read per bank, output bank chosen by current mem_a[14].
    logic [31:0] ram [0:32767];
    logic [31:0] q0;
    logic [31:0] q1;

    always @(posedge clk) begin
        logic [31:0] nw;
        nw = ram[mem_a];
        for (int i = 0; i < 4; i++)
            if (mem_bmsk[i]) nw[8*i +: 8] = mem_vi[8*i +: 8];
        q0 <= ram[{1'b0, mem_a[13:0]}];
        q1 <= ram[{1'b1, mem_a[13:0]}];
        if (mem_we) ram[mem_a] <= nw;
    end

    assign mem_vo = mem_a[14] ? q1 : q0;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic sgn,
                          input logic [16:0] addr, input logic [31:0] wd);
        int n;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (bus.req_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL req_ready_timeout got=%b exp=1", bus.req_ready);
        end
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_sz    = sz;
        bus.req_sgn   = sgn;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        tick();
        acc_cyc = cyc - 1;
        bus.req_valid = 1'b0;
        bus.req_addr  = 17'h1ABCD;
        bus.req_wdata = 32'h5A5A5A5A;
    endtask

    task automatic wait_rsp(output int lat, output logic [31:0] data);
        int n;
        n    = 0;
        lat  = -1;
        data = '0;
        while (bus.rsp_valid !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        if (bus.rsp_valid === 1'b1) begin
            lat  = cyc - acc_cyc;
            data = bus.rsp_rdata;
        end
    endtask

    task automatic test_reset();
        int lat;
        logic [31:0] rd;
        rst           = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_sz    = 2'd2;
        bus.req_sgn   = 1'b0;
        bus.req_addr  = 17'h00100;
        bus.req_wdata = 32'hCAFEF00D;
        tick();
        tick();
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0", bus.rsp_valid); end
        checks++; if (bus.rsp_rdata !== 32'h0) begin failures++; $display("FAIL rst_rsp_rdata got=%h exp=0", bus.rsp_rdata); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
        checks++; if (mem_bmsk !== 4'b0000) begin failures++; $display("FAIL rst_mem_bmsk got=%b exp=0000", mem_bmsk); end
        checks++; if (mem_a !== 15'h0) begin failures++; $display("FAIL rst_mem_a got=%h exp=0", mem_a); end
        checks++; if (mem_vi !== 32'h0) begin failures++; $display("FAIL rst_mem_vi got=%h exp=0", mem_vi); end
        rst = 1'b0;
        tick();
        acc_cyc = cyc - 1;
        bus.req_valid = 1'b0;
        checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL rst_first_accept_ready got=%b exp=0", bus.req_ready); end
        checks++; if (mem_we !== 1'b1 || mem_a !== 15'h0040) begin failures++; $display("FAIL rst_first_accept_bus got=we%b/a%h exp=we1/a0040", mem_we, mem_a); end
        wait_rsp(lat, rd);
        checks++; if (lat !== 2) begin failures++; $display("FAIL rst_first_store_lat got=%0d exp=2", lat); end
    endtask

    task automatic test_aligned_word();
        int lat;
        logic [31:0] rd;
        do_req(1'b1, 2'd2, 1'b0, 17'h00010, 32'hDEADBEEF);
        checks++; if (mem_a !== 15'h0004) begin failures++; $display("FAIL aw_st_a got=%h exp=0004", mem_a); end
        checks++; if (mem_bmsk !== 4'b1111) begin failures++; $display("FAIL aw_st_bmsk got=%b exp=1111", mem_bmsk); end
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL aw_st_we got=%b exp=1", mem_we); end
        checks++; if (mem_vi !== 32'hDEADBEEF) begin failures++; $display("FAIL aw_st_vi got=%h exp=deadbeef", mem_vi); end
        wait_rsp(lat, rd);
        checks++; if (lat !== 2) begin failures++; $display("FAIL aw_st_lat got=%0d exp=2", lat); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL aw_st_we_one_cycle got=%b exp=0", mem_we); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL aw_st_rdata got=%h exp=0", rd); end
        do_req(1'b0, 2'd2, 1'b0, 17'h00010, 32'h0);
        checks++; if (mem_we !== 1'b0 || mem_bmsk !== 4'b0000) begin failures++; $display("FAIL aw_ld_bus got=we%b/m%b exp=we0/m0000", mem_we, mem_bmsk); end
        wait_rsp(lat, rd);
        checks++; if (lat !== 3) begin failures++; $display("FAIL aw_ld_lat got=%0d exp=3", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL aw_ld_data got=%h exp=deadbeef", rd); end
    endtask

    task automatic test_byte_lanes();
        int lat;
        logic [31:0] rd;
        do_req(1'b1, 2'd0, 1'b0, 17'h00013, 32'h000000A5);
        checks++; if (mem_bmsk !== 4'b1000) begin failures++; $display("FAIL bl_st_bmsk got=%b exp=1000", mem_bmsk); end
        checks++; if (mem_vi[31:24] !== 8'hA5) begin failures++; $display("FAIL bl_st_vi got=%h exp=a5", mem_vi[31:24]); end
        wait_rsp(lat, rd);
        checks++; if (lat !== 2) begin failures++; $display("FAIL bl_st_lat got=%0d exp=2", lat); end
        do_req(1'b0, 2'd0, 1'b1, 17'h00013, 32'h0);
        wait_rsp(lat, rd);
        checks++; if (rd !== 32'hFFFFFFA5) begin failures++; $display("FAIL bl_ld_signed got=%h exp=ffffffa5", rd); end
        do_req(1'b0, 2'd0, 1'b0, 17'h00013, 32'h0);
        wait_rsp(lat, rd);
        checks++; if (rd !== 32'h000000A5) begin failures++; $display("FAIL bl_ld_unsigned got=%h exp=000000a5", rd); end
        do_req(1'b0, 2'd1, 1'b1, 17'h00010, 32'h0);
        wait_rsp(lat, rd);
        checks++; if (rd !== 32'hFFFFBEEF) begin failures++; $display("FAIL bl_ld_half_low got=%h exp=ffffbeef", rd); end
    endtask

    task automatic test_unaligned_word();
        int lat;
        logic [31:0] rd;
        do_req(1'b1, 2'd2, 1'b0, 17'h00006, 32'h11223344);
        checks++; if (mem_a !== 15'h0001 || mem_bmsk !== 4'b1100) begin failures++; $display("FAIL uw_st_c1 got=a%h/m%b exp=a0001/m1100", mem_a, mem_bmsk); end
        checks++; if (mem_vi !== 32'h33441122) begin failures++; $display("FAIL uw_st_vi got=%h exp=33441122", mem_vi); end
        tick();
        checks++; if (mem_a !== 15'h0002 || mem_bmsk !== 4'b0011 || mem_we !== 1'b1) begin failures++; $display("FAIL uw_st_c2 got=a%h/m%b/we%b exp=a0002/m0011/we1", mem_a, mem_bmsk, mem_we); end
        wait_rsp(lat, rd);
        checks++; if (lat !== 3) begin failures++; $display("FAIL uw_st_lat got=%0d exp=3", lat); end
        do_req(1'b0, 2'd2, 1'b0, 17'h00006, 32'h0);
        wait_rsp(lat, rd);
        checks++; if (lat !== 5) begin failures++; $display("FAIL uw_ld_lat got=%0d exp=5", lat); end
        checks++; if (rd !== 32'h11223344) begin failures++; $display("FAIL uw_ld_data got=%h exp=11223344", rd); end
    endtask

    task automatic test_bank_wrap();
        int lat;
        logic [31:0] rd;
        do_req(1'b1, 2'd1, 1'b0, 17'h0FFFF, 32'h0000BEEF);
        checks++; if (mem_a !== 15'h3FFF || mem_bmsk !== 4'b1000) begin failures++; $display("FAIL bw_hs_c1 got=a%h/m%b exp=a3fff/m1000", mem_a, mem_bmsk); end
        checks++; if (mem_vi !== 32'hEF0000BE) begin failures++; $display("FAIL bw_hs_vi got=%h exp=ef0000be", mem_vi); end
        tick();
        checks++; if (mem_a !== 15'h4000 || mem_bmsk !== 4'b0001) begin failures++; $display("FAIL bw_hs_c2 got=a%h/m%b exp=a4000/m0001", mem_a, mem_bmsk); end
        wait_rsp(lat, rd);
        do_req(1'b0, 2'd1, 1'b1, 17'h0FFFF, 32'h0);
        wait_rsp(lat, rd);
        checks++; if (lat !== 5 || rd !== 32'hFFFFBEEF) begin failures++; $display("FAIL bw_hl_data got=lat%0d/%h exp=lat5/ffffbeef", lat, rd); end
        do_req(1'b1, 2'd2, 1'b0, 17'h1FFFE, 32'h55667788);
        checks++; if (mem_a !== 15'h7FFF || mem_bmsk !== 4'b1100) begin failures++; $display("FAIL bw_ws_c1 got=a%h/m%b exp=a7fff/m1100", mem_a, mem_bmsk); end
        tick();
        checks++; if (mem_a !== 15'h0000 || mem_bmsk !== 4'b0011) begin failures++; $display("FAIL bw_ws_c2 got=a%h/m%b exp=a0000/m0011", mem_a, mem_bmsk); end
        wait_rsp(lat, rd);
        do_req(1'b0, 2'd3, 1'b0, 17'h1FFFE, 32'h0);
        wait_rsp(lat, rd);
        checks++; if (rd !== 32'h55667788) begin failures++; $display("FAIL bw_wl_data got=%h exp=55667788", rd); end
    endtask

    task automatic test_reset_mid_split();
        int lat;
        int pulses;
        logic [31:0] rd;
        do_req(1'b0, 2'd2, 1'b0, 17'h00006, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rm_ready got=%b exp=1", bus.req_ready); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rm_mem_we got=%b exp=0", mem_we); end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.rsp_valid === 1'b1) pulses++;
            tick();
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL rm_no_rsp got=%0d exp=0", pulses); end
        do_req(1'b0, 2'd2, 1'b0, 17'h00010, 32'h0);
        wait_rsp(lat, rd);
        checks++; if (lat !== 3 || rd !== 32'hA5ADBEEF) begin failures++; $display("FAIL rm_after_load got=lat%0d/%h exp=lat3/a5adbeef", lat, rd); end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) ram[i] = 32'h0;
        test_reset();
        test_aligned_word();
        test_byte_lanes();
        test_unaligned_word();
        test_bank_wrap();
        test_reset_mid_split();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
